// File: rtl/vend_pkg.sv
// Shared constants for the vending front end: coin codes and conditioner state encoding.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESS_W  = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_REL_WAIT = 2'd3;

    // Only the 5 and 10 codes are payable; 00 and 11 are rejected.
    function automatic logic coin_is_payable(input logic [1:0] code);
        return (code == COIN_5) || (code == COIN_10);
    endfunction

endpackage

// File: rtl/coin_input_conditioner_sync_2ff.sv
// Two-flop synchroniser for a bundle of asynchronous inputs into the clk domain.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/coin_input_conditioner.sv
// Insert-button debouncer and coin-code stability checker; emits one strobe per accepted press.
module coin_input_conditioner
    import vend_pkg::*;
#(
    parameter int DB_CYCLES = 250000,
    parameter int CNT_W     = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [1:0] coin_raw,
    output logic       coin_valid,
    output logic [1:0] coin_code,
    output logic       reject,
    output logic       btn_db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [2:0]       w_sync;
    logic             w_bs;
    logic [1:0]       w_cs;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_cap;

    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_cap_next;
    logic             w_accept;

    sync_2ff #(.W(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({btn_raw, coin_raw}),
        .q   (w_sync)
    );

    assign w_bs = w_sync[2];
    assign w_cs = w_sync[1:0];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cap_next   = r_cap;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_bs) begin
                    w_state_next = ST_PRESS_W;
                    w_cnt_next   = '0;
                    w_cap_next   = w_cs;
                end
            end
            ST_PRESS_W: begin
                if (!w_bs) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (w_cs != r_cap) begin
                    // Code moved under a held button: restart the stability window on the new code.
                    w_cnt_next = '0;
                    w_cap_next = w_cs;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_HELD;
                    w_cnt_next   = '0;
                    w_accept     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!w_bs) begin
                    w_state_next = ST_REL_WAIT;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                if (w_bs) begin
                    w_state_next = ST_HELD;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
        endcase
    end

    // Reset lands in REL_WAIT so a button held through reset must be released before it counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_REL_WAIT;
            r_cnt      <= '0;
            r_cap      <= COIN_NONE;
            coin_valid <= 1'b0;
            reject     <= 1'b0;
            coin_code  <= COIN_NONE;
            btn_db     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_cap      <= w_cap_next;
            coin_valid <= w_accept && coin_is_payable(r_cap);
            reject     <= w_accept && !coin_is_payable(r_cap);
            if (w_accept) begin
                coin_code <= r_cap;
            end
            btn_db     <= (w_state_next == ST_HELD) || (w_state_next == ST_REL_WAIT);
        end
    end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed and randomised checks of coin_input_conditioner against a run-length reference model.
module tb_coin_input_conditioner;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b0;
    logic [1:0] coin_raw = 2'b00;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       reject;
    logic       btn_db;

    coin_input_conditioner #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .coin_raw   (coin_raw),
        .coin_valid (coin_valid),
        .coin_code  (coin_code),
        .reject     (reject),
        .btn_db     (btn_db)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int cnt_valid  = 0;
    int cnt_reject = 0;
    int last_strobe_cyc = -1;

    // Reference model: press accepted after DB+1 consecutive pressed samples with one code;
    // re-armed after DB+1 consecutive released samples (DB straight after reset).
    logic       d1 = 0, d2 = 0;
    logic [1:0] cd1 = 0, cd2 = 0;
    bit         m_armed = 0;
    int         m_rel_need = DB;
    int         m_zero = 0;
    int         m_streak = 0;
    logic [1:0] m_scode = 0;
    logic       exp_valid = 0, exp_reject = 0, exp_db = 0;
    logic [1:0] exp_code = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic model_edge();
        logic       b;
        logic [1:0] c;
        if (rst) begin
            m_armed = 0; m_rel_need = DB; m_zero = 0; m_streak = 0;
            exp_valid = 0; exp_reject = 0; exp_code = 0; exp_db = 0;
            d1 = 0; d2 = 0; cd1 = 0; cd2 = 0;
        end else begin
            b = d2;
            c = cd2;
            exp_valid = 0;
            exp_reject = 0;
            if (m_armed) begin
                if (b) begin
                    if (m_streak > 0 && c == m_scode) m_streak++;
                    else begin
                        m_streak = 1;
                        m_scode  = c;
                    end
                    if (m_streak == DB + 1) begin
                        m_armed = 0; m_zero = 0; m_rel_need = DB + 1; m_streak = 0;
                        exp_code = m_scode;
                        if (m_scode == 2'b01 || m_scode == 2'b10) exp_valid = 1;
                        else exp_reject = 1;
                    end
                end else begin
                    m_streak = 0;
                end
            end else begin
                if (b) begin
                    m_zero = 0;
                    m_rel_need = DB + 1;
                end else begin
                    m_zero++;
                    if (m_zero == m_rel_need) begin
                        m_armed = 1;
                        m_streak = 0;
                    end
                end
            end
            exp_db = !m_armed;
            d2 = d1; d1 = btn_raw; cd2 = cd1; cd1 = coin_raw;
        end
    endtask

    task automatic step(input logic b, input logic [1:0] c);
        btn_raw  = b;
        coin_raw = c;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk("coin_valid", 32'(coin_valid), 32'(exp_valid));
        chk("reject",     32'(reject),     32'(exp_reject));
        chk("coin_code",  32'(coin_code),  32'(exp_code));
        chk("btn_db",     32'(btn_db),     32'(exp_db));
        if (coin_valid === 1'b1 || reject === 1'b1) begin
            cnt_valid  += int'(coin_valid === 1'b1);
            cnt_reject += int'(reject === 1'b1);
            last_strobe_cyc = cyc;
            $display("cycle %0d: strobe valid=%0b reject=%0b code=%02b", cyc, coin_valid, reject, coin_code);
        end
    endtask

    task automatic steps(input int n, input logic b, input logic [1:0] c);
        for (int i = 0; i < n; i++) step(b, c);
    endtask

    task automatic clear_counts();
        cnt_valid = 0;
        cnt_reject = 0;
    endtask

    initial begin
        int press_cyc;
        int run;
        logic       rb;
        logic [1:0] rc;

        // Reset state
        rst = 1'b1;
        steps(3, 1'b0, 2'b00);
        chk("reset_valid", 32'(coin_valid), 32'd0);
        chk("reset_code",  32'(coin_code),  32'd0);
        chk("reset_db",    32'(btn_db),     32'd0);
        rst = 1'b0;

        // 1: clean press, latency
        clear_counts();
        steps(6, 1'b0, 2'b00);
        step(1'b1, 2'b01);
        press_cyc = cyc;
        steps(19, 1'b1, 2'b01);
        chk("t1_valid_count",  32'(cnt_valid),  32'd1);
        chk("t1_reject_count", 32'(cnt_reject), 32'd0);
        chk("t1_latency", 32'(last_strobe_cyc - press_cyc + 1), 32'(DB + 3));
        chk("t1_code", 32'(coin_code), 32'b01);
        steps(8, 1'b0, 2'b01);

        // 2: bouncy press
        clear_counts();
        step(1'b1, 2'b10); step(1'b0, 2'b10); step(1'b1, 2'b10); step(1'b0, 2'b10);
        chk("t2_bounce_quiet", 32'(cnt_valid + cnt_reject), 32'd0);
        steps(12, 1'b1, 2'b10);
        chk("t2_valid_count", 32'(cnt_valid), 32'd1);
        chk("t2_code", 32'(coin_code), 32'b10);
        steps(8, 1'b0, 2'b10);

        // 3: code changes mid-debounce
        clear_counts();
        steps(3, 1'b1, 2'b01);
        steps(12, 1'b1, 2'b10);
        chk("t3_valid_count", 32'(cnt_valid), 32'd1);
        chk("t3_code", 32'(coin_code), 32'b10);
        steps(8, 1'b0, 2'b10);

        // 4: bad codes
        clear_counts();
        steps(10, 1'b1, 2'b11);
        chk("t4_code_11", 32'(coin_code), 32'b11);
        steps(8, 1'b0, 2'b11);
        steps(10, 1'b1, 2'b00);
        chk("t4_code_00", 32'(coin_code), 32'b00);
        steps(8, 1'b0, 2'b00);
        chk("t4_reject_count", 32'(cnt_reject), 32'd2);
        chk("t4_valid_count",  32'(cnt_valid),  32'd0);

        // 5: release bounce, coin switch ignored while held
        clear_counts();
        steps(10, 1'b1, 2'b01);
        steps(2, 1'b0, 2'b10);
        steps(8, 1'b1, 2'b10);
        chk("t5_valid_count", 32'(cnt_valid + cnt_reject), 32'd1);
        chk("t5_db_held", 32'(btn_db), 32'd1);
        chk("t5_code_kept", 32'(coin_code), 32'b01);
        steps(8, 1'b0, 2'b01);

        // 6: held through reset, reset mid-press
        clear_counts();
        step(1'b1, 2'b01);
        rst = 1'b1; steps(3, 1'b1, 2'b01); rst = 1'b0;
        steps(15, 1'b1, 2'b01);
        steps(8, 1'b0, 2'b01);
        steps(4, 1'b1, 2'b01);
        rst = 1'b1; steps(2, 1'b1, 2'b01); rst = 1'b0;
        steps(12, 1'b1, 2'b01);
        chk("t6_no_strobe", 32'(cnt_valid + cnt_reject), 32'd0);
        steps(8, 1'b0, 2'b01);
        steps(10, 1'b1, 2'b10);
        chk("t6_after_release", 32'(cnt_valid), 32'd1);
        steps(8, 1'b0, 2'b10);

        // Randomised runs checked cycle by cycle against the model
        for (int t = 0; t < 60; t++) begin
            rb  = 1'($urandom_range(0, 1));
            rc  = 2'($urandom_range(0, 3));
            run = (t % 3 == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(3, 9));
            for (int k = 0; k < run; k++) begin
                if ($urandom_range(0, 7) == 0) rc = 2'($urandom_range(0, 3));
                step(rb, rc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
